// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider sequencer and its phase shadow.
// Period width, legal range and reset period all live here.
package clk_div_pkg;

  localparam int W          = 11;
  localparam int MIN_PERIOD = 2;
  localparam int DEF_PERIOD = 4;
  localparam int CNT_W      = W - 1;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_SWITCH
  } state_e;

  typedef logic [W-1:0]     period_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Terminal count of one half-phase; odd periods truncate like the divider does.
  function automatic cnt_t half_limit(input period_t p);
    period_t h;
    h = p >> 1;
    return cnt_t'(h) - cnt_t'(1);
  endfunction

  function automatic logic is_legal(input period_t p);
    return (p >= period_t'(MIN_PERIOD));
  endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Cycle-exact mirror of the divider counter/clk_out; phase and tick are registered, 1-cycle update.
// No backpressure: clear wins over load, load wins over normal counting.
module clk_div_shadow
  import clk_div_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_period,
  output logic         o_wrap,
  output logic         o_phase,
  output logic         o_tick
);

  cnt_t r_cnt;
  logic r_phase;
  logic r_tick;
  logic w_wrap;

  assign w_wrap = (r_cnt == half_limit(i_period));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_tick  <= 1'b0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_tick  <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_tick  <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
      r_tick  <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + cnt_t'(1);
      r_tick  <= 1'b0;
    end
  end

  assign o_wrap  = w_wrap;
  assign o_phase = r_phase;
  assign o_tick  = r_tick;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider sequencer: owns divider reset/period, applies new periods at falling-edge points; outputs registered, 1 cycle.
// cfg_ready drops while a switch is pending; a held request is taken the cycle after busy clears.
module clk_div_ctrl
  import clk_div_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_cfg_valid,
  input  logic [W-1:0] i_cfg_period,
  output logic         o_cfg_ready,
  output logic         o_cfg_err,
  output logic         o_div_rst_n,
  output logic [W-1:0] o_div_period,
  output logic         o_div_phase,
  output logic         o_tick,
  output logic         o_busy
);

  state_e  r_state;
  period_t r_div_period;
  period_t r_pend;
  logic    r_div_rst_n;
  logic    r_cfg_ready;
  logic    r_cfg_err;
  logic    r_busy;

  logic w_accept;
  logic w_legal;
  logic w_wrap;
  logic w_phase;
  logic w_clear;
  logic w_load;

  assign w_accept = i_cfg_valid & r_cfg_ready;
  assign w_legal  = is_legal(i_cfg_period);
  assign w_clear  = (r_state == ST_STOP) | ~i_en;
  // Switch point: last cycle of the high phase, so the new period starts a fresh low phase.
  assign w_load   = (r_state == ST_SWITCH) & w_wrap & w_phase;

  clk_div_shadow u_shadow (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_clear),
    .i_load   (w_load),
    .i_period (r_div_period),
    .o_wrap   (w_wrap),
    .o_phase  (w_phase),
    .o_tick   (o_tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_STOP;
      r_div_period <= period_t'(DEF_PERIOD);
      r_pend       <= period_t'(DEF_PERIOD);
      r_div_rst_n  <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_cfg_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_cfg_err <= w_accept & ~w_legal;
      case (r_state)
        ST_STOP: begin
          if (w_accept && w_legal) r_div_period <= i_cfg_period;
          if (i_en) begin
            r_state     <= ST_RUN;
            r_div_rst_n <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!i_en) begin
            r_state     <= ST_STOP;
            r_div_rst_n <= 1'b0;
            if (w_accept && w_legal) r_div_period <= i_cfg_period;
          end else if (w_accept && w_legal) begin
            r_pend      <= i_cfg_period;
            r_state     <= ST_SWITCH;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
          end
        end
        ST_SWITCH: begin
          if (!i_en) begin
            r_state      <= ST_STOP;
            r_div_rst_n  <= 1'b0;
            r_div_period <= r_pend;
            r_busy       <= 1'b0;
            r_cfg_ready  <= 1'b1;
          end else if (w_load) begin
            r_state      <= ST_RUN;
            r_div_period <= r_pend;
            r_busy       <= 1'b0;
            r_cfg_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_STOP;
          r_div_rst_n <= 1'b0;
          r_busy      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_cfg_ready  = r_cfg_ready;
  assign o_cfg_err    = r_cfg_err;
  assign o_div_rst_n  = r_div_rst_n;
  assign o_div_period = r_div_period;
  assign o_div_phase  = w_phase;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl driving a behavioural divider; checked every cycle against a period-level model.
module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic [10:0] cfg_period;
  logic        cfg_ready;
  logic        cfg_err;
  logic        div_rst_n;
  logic [10:0] div_period;
  logic        div_phase;
  logic        tick;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clk_div_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_cfg_valid  (cfg_valid),
    .i_cfg_period (cfg_period),
    .o_cfg_ready  (cfg_ready),
    .o_cfg_err    (cfg_err),
    .o_div_rst_n  (div_rst_n),
    .o_div_period (div_period),
    .o_div_phase  (div_phase),
    .o_tick       (tick),
    .o_busy       (busy)
  );

  // The divider being sequenced: async active-low reset, toggles every period/2 clocks.
  logic [10:0] d_cnt;
  logic        d_out;
  always @(posedge clk or negedge div_rst_n) begin
    if (!div_rst_n) begin
      d_cnt <= 11'd0;
      d_out <= 1'b0;
    end else if (d_cnt == (div_period >> 1) - 11'd1) begin
      d_cnt <= 11'd0;
      d_out <= ~d_out;
    end else begin
      d_cnt <= d_cnt + 11'd1;
    end
  end

  // Reference model: running flag, applied period, optional pending period, clk_out age/level.
  int m_run, m_period, m_pend_v, m_pend, m_age, m_out, m_tick, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_period = 4; m_pend_v = 0; m_pend = 0;
    m_age = 0; m_out = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input int p);
    bit acc, leg, rose, fell;
    acc = v && (m_pend_v == 0);
    leg = (p >= 2);
    m_err = (acc && !leg) ? 1 : 0;
    rose = 0; fell = 0;
    if (m_run != 0) begin
      if (m_age + 1 == m_period / 2) begin
        m_age = 0;
        m_out = 1 - m_out;
        rose = (m_out == 1);
        fell = (m_out == 0);
      end else begin
        m_age++;
      end
    end
    if (m_run == 0) begin
      if (acc && leg) m_period = p;
      m_run = e ? 1 : 0;
    end else if (!e) begin
      m_run = 0; m_age = 0; m_out = 0; rose = 0;
      if (m_pend_v != 0) begin
        m_period = m_pend; m_pend_v = 0;
      end else if (acc && leg) begin
        m_period = p;
      end
    end else if (m_pend_v != 0) begin
      if (fell) begin
        m_period = m_pend; m_pend_v = 0;
      end
    end else if (acc && leg) begin
      m_pend_v = 1; m_pend = p;
    end
    m_tick = rose ? 1 : 0;
  endtask

  task automatic check_all();
    chk("div_rst_n", div_rst_n, m_run);
    chk("div_period", div_period, m_period);
    chk("div_phase", div_phase, m_out);
    chk("clk_out", d_out, m_out);
    chk("tick", tick, m_tick);
    chk("busy", busy, m_pend_v);
    chk("cfg_ready", cfg_ready, (m_pend_v == 0) ? 1 : 0);
    chk("cfg_err", cfg_err, m_err);
  endtask

  task automatic cyc(input bit e, input bit v, input int p);
    logic [10:0] pv;
    pv = p[10:0];
    en = e; cfg_valid = v; cfg_period = pv;
    @(posedge clk);
    model_step(e, v, p);
    #1;
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rst_n"}, div_rst_n, 0);
    chk({tag, "_period"}, div_period, 4);
    chk({tag, "_phase"}, div_phase, 0);
    chk({tag, "_clk_out"}, d_out, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, cfg_ready, 1);
    chk({tag, "_err"}, cfg_err, 0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_vals(tag);
    model_reset();
    en = 1'b0; cfg_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, lat;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = 11'd0;
    model_reset();
    #2 check_reset_vals("por");
    @(posedge clk);
    #1 rst = 1'b0;

    // Default period 4: start running.
    for (int i = 0; i < 14; i++) cyc(1, 0, 0);

    // Offer 10 while high; switch waits for the falling point.
    n = 0;
    while (m_out == 0 && n < 8) begin cyc(1, 0, 0); n++; end
    cyc(1, 1, 10);
    lat = 0;
    while (m_pend_v != 0 && lat < 20) begin cyc(1, 0, 0); lat++; end
    chk("sw_done", busy, 0);
    chk("sw_latency_ok", (lat <= 5) ? 1 : 0, 1);
    n = 0;
    while (div_phase !== 1'b1 && n < 20) begin cyc(1, 0, 0); n++; end
    hi = 0;
    while (div_phase === 1'b1 && hi < 40) begin hi++; cyc(1, 0, 0); end
    chk("hi_len", hi, 5);

    // Illegal periods rejected.
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);

    // Request held across a pending switch.
    cyc(1, 1, 4);
    n = 0;
    while (m_pend_v != 0 && n < 40) begin cyc(1, 1, 8); n++; end
    cyc(1, 1, 8);
    chk("held_accept", busy, 1);
    n = 0;
    while (m_pend_v != 0 && n < 40) begin cyc(1, 0, 0); n++; end
    chk("held_done", busy, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);

    // Disable during a switch: pending period lands in div_period.
    cyc(1, 1, 6);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("stop_period", div_period, 6);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0);

    // Odd period 7 truncates to half 3; then async reset mid-run.
    cyc(0, 0, 0);
    cyc(0, 1, 7);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0);
    async_reset("arst");
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rand_arst");
      end else begin
        cyc(($urandom % 16) != 0, ($urandom % 4) == 0, int'($urandom_range(0, 12)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
